// File: rtl/sha_core_unroll.sv
// sha_core_unroll: SHA-256 compression core evaluating ROUNDS_PER_CYCLE
// rounds per clock (1, 2 or 4).
// The message schedule is a 16-word sliding window, so no 64-entry W storage is kept.
// Optional feature macro: SHA_CORE_UNROLL_ABORT_EN adds an abort input that
// drops the hash in flight.
module sha_core_unroll #(
   parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
`ifdef SHA_CORE_UNROLL_ABORT_EN
   input  logic         abort,
`endif
   input  logic         start,
   input  logic [255:0] start_state,
   input  logic [511:0] input_message,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [255:0] result
);

   localparam int unsigned R        = ROUNDS_PER_CYCLE;
   localparam int unsigned LATENCY  = 64 / ROUNDS_PER_CYCLE;
   localparam logic [5:0]  LAST_CNT = 6'((LATENCY - 1) * R);
   localparam logic [5:0]  STEP     = 6'(R);

   generate
      if (R != 1 && R != 2 && R != 4) begin : g_bad_rounds
         $error("sha_core_unroll: ROUNDS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic {S_IDLE, S_RUN} state_t;

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   state_t        state_q, state_d;
   logic [5:0]    cnt_q, cnt_d;
   logic [255:0]  h0_q, h0_d;       // chaining value captured on accept
   logic [255:0]  wk_q, wk_d;       // working variables a..h, a in [255:224]
   logic [511:0]  win_q, win_d;     // schedule window W[t..t+15], W[t] in [511:480]
   logic [255:0]  result_q, result_d;
   logic          done_q, done_d;

   logic [255:0]  wk_next;
   logic [511:0]  win_next;
   logic          abort_w;

`ifdef SHA_CORE_UNROLL_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   // R chained compression rounds plus R new schedule words for this edge
   always_comb begin : p_rounds
      logic [31:0] ext [20];
      logic [31:0] v [8];
      logic [31:0] t1;
      logic [31:0] t2;
      for (int unsigned i = 0; i < 20; i++) ext[i] = '0;
      for (int unsigned i = 0; i < 8; i++) v[i] = '0;
      t1 = '0;
      t2 = '0;
      wk_next  = '0;
      win_next = '0;
      for (int unsigned i = 0; i < 16; i++) ext[i] = win_q[511 - 32*i -: 32];
      // later words may depend on words generated earlier in the same edge
      for (int unsigned j = 0; j < R; j++) begin
         ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
      end
      for (int unsigned i = 0; i < 8; i++) v[i] = wk_q[255 - 32*i -: 32];
      for (int unsigned j = 0; j < R; j++) begin
         t1 = v[7] + big_sigma1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
            + K[cnt_q + 6'(j)] + ext[j];
         t2 = big_sigma0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         v[7] = v[6];
         v[6] = v[5];
         v[5] = v[4];
         v[4] = v[3] + t1;
         v[3] = v[2];
         v[2] = v[1];
         v[1] = v[0];
         v[0] = t1 + t2;
      end
      for (int unsigned i = 0; i < 8; i++) wk_next[255 - 32*i -: 32] = v[i];
      for (int unsigned i = 0; i < 16; i++) win_next[511 - 32*i -: 32] = ext[i+R];
   end

   // Next-state logic: accept in IDLE, advance rounds in RUN, finish or abort
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      h0_d     = h0_q;
      wk_d     = wk_q;
      win_d    = win_q;
      result_d = result_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               cnt_d   = '0;
               h0_d    = start_state;
               wk_d    = start_state;
               win_d   = input_message;
            end
         end
         S_RUN: begin
            if (abort_w) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               wk_d  = wk_next;
               win_d = win_next;
               cnt_d = cnt_q + STEP;
               if (cnt_q == LAST_CNT) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  for (int unsigned i = 0; i < 8; i++) begin
                     result_d[255 - 32*i -: 32] = h0_q[255 - 32*i -: 32] + wk_next[255 - 32*i -: 32];
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset; reset overrides a coincident start
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         h0_q     <= '0;
         wk_q     <= '0;
         win_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         h0_q     <= h0_d;
         wk_q     <= wk_d;
         win_q    <= win_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign ready  = (state_q == S_IDLE);
   assign busy   = (state_q == S_RUN);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_sha_core_unroll.sv
// Bench for sha_core_unroll: one instance each for 1, 2 and 4 rounds per cycle,
// exercised in turn against a behavioural SHA-256 reference model.
module tb_sha_core_unroll;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [2:0]   start_v, ready_v, busy_v, done_v;
`ifdef SHA_CORE_UNROLL_ABORT_EN
   logic [2:0]   abort_v;
`endif
   logic [255:0] iv_v  [3];
   logic [511:0] msg_v [3];
   logic [255:0] res_v [3];

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
   localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sha_core_unroll #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
         .clk           (clk),
         .rst           (rst),
`ifdef SHA_CORE_UNROLL_ABORT_EN
         .abort         (abort_v[g]),
`endif
         .start         (start_v[g]),
         .start_state   (iv_v[g]),
         .input_message (msg_v[g]),
         .ready         (ready_v[g]),
         .busy          (busy_v[g]),
         .done          (done_v[g]),
         .result        (res_v[g])
      );
   end

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Straightforward SHA-256 compression with the full 64-word schedule
   function automatic logic [255:0] sha_ref(input logic [255:0] iv, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] h [8];
      logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
      logic [255:0] out;
      for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
              + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      end
      for (int i = 0; i < 8; i++) h[i] = iv[255 - 32*i -: 32];
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int i = 0; i < 64; i++) begin
         t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[i] + w[i];
         t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      out = {h[0] + a, h[1] + b, h[2] + c, h[3] + d, h[4] + e, h[5] + f, h[6] + g, h[7] + hh};
      return out;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r = '0;
      for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
      return r;
   endfunction

   function automatic logic [511:0] rnd512();
      logic [511:0] r = '0;
      for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom())};
      return r;
   endfunction

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after the accept edge
   task automatic accept(input int d, input logic [255:0] iv, input logic [511:0] blk, input string tag);
      check_eq($sformatf("%s_ready_idle", tag), 256'(ready_v[d]), 256'd1);
      iv_v[d]    = iv;
      msg_v[d]   = blk;
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
   endtask

   // Starts at the negedge right after the accept edge; returns at the done negedge
   task automatic wait_done(input int d, input int unsigned lat, input logic [255:0] exp,
                            input bit hold, input string tag);
      int unsigned n = 0;
      int unsigned at = 0;
      bit seen = 1'b0;
      check_eq($sformatf("%s_busy", tag), 256'(busy_v[d]), 256'd1);
      check_eq($sformatf("%s_notready", tag), 256'(ready_v[d]), 256'd0);
      while (!seen && n < lat + 8) begin
         if (n == 2) begin
            iv_v[d]  = rnd256();
            msg_v[d] = rnd512();
            if (!hold) start_v[d] = 1'b1;
         end
         if (n == 3 && !hold) start_v[d] = 1'b0;
         @(negedge clk);
         n++;
         if (done_v[d]) begin
            seen = 1'b1;
            at   = n;
         end
      end
      check_eq($sformatf("%s_latency", tag), 256'(at), 256'(lat));
      check_eq($sformatf("%s_digest", tag), res_v[d], exp);
      check_eq($sformatf("%s_ready_done", tag), 256'(ready_v[d]), 256'd1);
      check_eq($sformatf("%s_busy_done", tag), 256'(busy_v[d]), 256'd0);
   endtask

   task automatic pulse_end(input int d, input logic [255:0] exp, input string tag);
      @(negedge clk);
      check_eq($sformatf("%s_pulse", tag), 256'(done_v[d]), 256'd0);
      check_eq($sformatf("%s_hold", tag), res_v[d], exp);
   endtask

   task automatic no_done(input int d, input int unsigned cycles, input string tag);
      int unsigned cnt = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (done_v[d]) cnt++;
      end
      check_eq($sformatf("%s_nodone", tag), 256'(cnt), 256'd0);
   endtask

   task automatic run_suite(input int d);
      int unsigned lat = 64 >> d;
      int unsigned r   = 1 << d;
      string p = $sformatf("r%0d", r);
      logic [255:0] riv;
      logic [511:0] rblk;
      logic [255:0] exp;

      accept(d, IV, ABC_BLK, {p, "_abc"});
      wait_done(d, lat, ABC_DIG, 1'b0, {p, "_abc"});
      pulse_end(d, ABC_DIG, {p, "_abc"});

      accept(d, IV, EMPTY_BLK, {p, "_empty"});
      wait_done(d, lat, EMPTY_DIG, 1'b0, {p, "_empty"});
      pulse_end(d, EMPTY_DIG, {p, "_empty"});

      // back-to-back with start held high across the done cycle
      iv_v[d] = IV; msg_v[d] = ABC_BLK; start_v[d] = 1'b1;
      @(negedge clk);
      wait_done(d, lat, ABC_DIG, 1'b1, {p, "_b2b1"});
      iv_v[d] = IV; msg_v[d] = EMPTY_BLK;
      @(negedge clk);
      start_v[d] = 1'b0;
      check_eq({p, "_b2b_pulse"}, 256'(done_v[d]), 256'd0);
      wait_done(d, lat, EMPTY_DIG, 1'b0, {p, "_b2b2"});
      pulse_end(d, EMPTY_DIG, {p, "_b2b2"});

      for (int k = 0; k < 2; k++) begin
         riv  = rnd256();
         rblk = rnd512();
         exp  = sha_ref(riv, rblk);
         accept(d, riv, rblk, $sformatf("%s_rnd%0d", p, k));
         wait_done(d, lat, exp, 1'b0, $sformatf("%s_rnd%0d", p, k));
         pulse_end(d, exp, $sformatf("%s_rnd%0d", p, k));
      end

      // reset in the middle of a hash, around round 20
      accept(d, IV, ABC_BLK, {p, "_rstmid"});
      repeat (20 / r) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq({p, "_rst_ready"}, 256'(ready_v[d]), 256'd1);
      check_eq({p, "_rst_busy"}, 256'(busy_v[d]), 256'd0);
      check_eq({p, "_rst_done"}, 256'(done_v[d]), 256'd0);
      check_eq({p, "_rst_result"}, res_v[d], 256'd0);
      no_done(d, lat + 4, {p, "_rstmid"});

      // reset and start on the same edge: the start is dropped
      iv_v[d] = IV; msg_v[d] = ABC_BLK; start_v[d] = 1'b1; rst = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0; rst = 1'b0;
      check_eq({p, "_rstst_ready"}, 256'(ready_v[d]), 256'd1);
      check_eq({p, "_rstst_busy"}, 256'(busy_v[d]), 256'd0);
      no_done(d, lat + 4, {p, "_rstst"});

      accept(d, IV, ABC_BLK, {p, "_postrst"});
      wait_done(d, lat, ABC_DIG, 1'b0, {p, "_postrst"});
      pulse_end(d, ABC_DIG, {p, "_postrst"});

`ifdef SHA_CORE_UNROLL_ABORT_EN
      // abort around round 10: result retained, no done
      accept(d, IV, EMPTY_BLK, {p, "_abort"});
      repeat (10 / r) @(negedge clk);
      abort_v[d] = 1'b1;
      @(negedge clk);
      abort_v[d] = 1'b0;
      check_eq({p, "_abort_ready"}, 256'(ready_v[d]), 256'd1);
      check_eq({p, "_abort_result"}, res_v[d], ABC_DIG);
      no_done(d, lat + 4, {p, "_abort"});

      // abort while idle must not block an accept
      riv  = rnd256();
      rblk = rnd512();
      exp  = sha_ref(riv, rblk);
      iv_v[d] = riv; msg_v[d] = rblk; start_v[d] = 1'b1; abort_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0; abort_v[d] = 1'b0;
      wait_done(d, lat, exp, 1'b0, {p, "_idleabort"});
      pulse_end(d, exp, {p, "_idleabort"});
`endif
   endtask

   initial begin
      rst = 1'b1;
      start_v = '0;
`ifdef SHA_CORE_UNROLL_ABORT_EN
      abort_v = '0;
`endif
      for (int i = 0; i < 3; i++) begin
         iv_v[i]  = '0;
         msg_v[i] = '0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("reset%0d_ready", i), 256'(ready_v[i]), 256'd1);
         check_eq($sformatf("reset%0d_busy", i), 256'(busy_v[i]), 256'd0);
         check_eq($sformatf("reset%0d_done", i), 256'(done_v[i]), 256'd0);
         check_eq($sformatf("reset%0d_result", i), res_v[i], 256'd0);
      end
      for (int i = 0; i < 3; i++) run_suite(i);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/sha_core_unroll.md
SHA_CORE_UNROLL -- requirements
Module: sha_core_unroll

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1: SHA-256 compression rounds evaluated per clock; legal values 1, 2, 4; any other value SHALL fail elaboration.
REQ-002 SHALL have parameter LATENCY (derived, not overridable) = 64/ROUNDS_PER_CYCLE.
REQ-003 SHALL use one clock; reset is synchronous and active-high; ports clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request a hash; accepted only when ready=1.
REQ-007 start_state  input  256  chaining value H0..H7, H0 in bits [255:224].
REQ-008 input_message  input  512  message block W0..W15, W0 in bits [511:480].
REQ-009 ready  output  1  high when idle and able to accept start.
REQ-010 busy  output  1  high while rounds are in progress.
REQ-011 done  output  1  one-cycle pulse when result becomes valid.
REQ-012 result  output  256  start_state + final working state, per 32-bit word, modulo 2^32.

Function
REQ-013 Accept = start && ready sampled at a rising edge; start_state and input_message SHALL be registered on accept; later input changes SHALL NOT affect the hash in flight.
REQ-014 FSM states: IDLE (ready=1, busy=0) and RUN (ready=0, busy=1); IDLE->RUN on accept; RUN->IDLE on the edge completing round 63.
REQ-015 In RUN, each edge SHALL apply ROUNDS_PER_CYCLE consecutive rounds using K[t] and W[t] for t = round counter .. counter+R-1.
REQ-016 Message schedule SHALL be a 16-word sliding window shifted by R words per edge: W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16] mod 2^32; no 48-entry storage.
REQ-017 Round counter SHALL be 6 bits, start at 0 on accept, advance by R per edge, and wrap to 0 on completion.
REQ-018 done SHALL be high exactly in the cycle following the LATENCY-th edge after the accept edge, for one cycle only.
REQ-019 result SHALL be registered at the same edge that raises done and held stable until the next completion or reset.
REQ-020 ready SHALL rise together with done; start during the done cycle SHALL be accepted (back-to-back throughput of one block per LATENCY+1 cycles).
REQ-021 start while busy=1 SHALL be ignored, with no effect on the hash in flight.
REQ-022 start and rst high at the same edge: reset SHALL win and the start SHALL be dropped.

Reset
REQ-023 rst at an edge SHALL force IDLE: ready=1, busy=0, done=0, result=0, round counter=0; working state and schedule window cleared.
REQ-024 rst during RUN SHALL abandon the hash; no done pulse SHALL follow for it.

Configuration
REQ-025 Macro SHA_CORE_UNROLL_ABORT_EN: when defined, SHALL add input abort (1 bit); abort=1 at an edge in RUN SHALL return to IDLE with ready=1 on the next cycle, no done, and result unchanged; abort in IDLE SHALL have no effect.
REQ-026 When SHA_CORE_UNROLL_ABORT_EN is undefined, the abort port SHALL NOT exist and behaviour SHALL be exactly REQ-013..REQ-024.

Verification
REQ-027 "abc": start_state=6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19, block 61626380 then 14 zero words then 00000018 -> result ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-028 Empty message: same IV, block 80000000 then 15 zero words -> result e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-029 Latency: for R=1, 2, 4, done is high exactly 64, 32, 16 cycles after the accept edge; single pulse; results identical to REQ-027 for each R.
REQ-030 Back-to-back: "abc" then empty block with start held high -> second accept in the done cycle; both digests correct; inputs changed mid-run are ignored.
REQ-031 rst pulsed at round 20 of a hash -> ready=1 next cycle, result=0, no done; a fresh "abc" afterwards yields the correct digest.
REQ-032 With SHA_CORE_UNROLL_ABORT_EN defined: abort at round 10 -> ready=1 next cycle, no done, previous result retained; the following hash is correct.
